// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller.
// Holds the address type, load/store size codes, FSM state encodings, the I/O
// region marker and the latched transfer payload.
package mem_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  typedef logic [ADDR_W_DEF-1:0] AddrType;

  // Load/store size codes; 2'd3 is illegal and handled as a word
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // addr[17:16] value marking the I/O region (0x30000 and above)
  localparam logic [1:0] IO_HI_DEF = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_IF_RD = 2'd1,
    ST_LS_RD = 2'd2,
    ST_LS_WR = 2'd3
  } state_e;

  typedef enum logic {
    SRC_IF = 1'b0,
    SRC_LS = 1'b1
  } src_e;

  // Transfer parameters captured at grant time
  typedef struct packed {
    logic [2:0]  nbytes;
    logic [31:0] wdata;
  } xfer_t;

  // Number of byte cycles for a load/store size code
  function automatic logic [2:0] byte_count(input logic [1:0] size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Requester and RAM-port bundle for mem_ctrl.
// slave  : the controller side (takes requests, drives done/data and the RAM port).
// master : the surrounding core / bench side.
interface mem_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  // instruction fetch channel
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [31:0]       if_inst;
  // load/store channel
  logic              ls_req;
  logic              ls_we;
  logic [1:0]        ls_size;
  logic [ADDR_W-1:0] ls_addr;
  logic [31:0]       ls_wdata;
  logic              ls_done;
  logic [31:0]       ls_rdata;
  // byte-wide RAM port
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata, mem_din,
    output if_done, if_inst, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata, mem_din,
    input  if_done, if_inst, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter between fetch and load/store.
// Ports: clk, rst (sync, active-high); i_req_if/i_req_ls pending requests;
// i_take commits the offered grant; o_valid_c/o_src_c combinational grant offer.
module rr_arb2
  import mem_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_req_if,
  input  logic i_req_ls,
  input  logic i_take,
  output logic o_valid_c,
  output src_e o_src_c
);

  src_e r_last;

  // Grant the single requester, or the one not served last on contention
  always_comb begin
    o_valid_c = i_req_if | i_req_ls;
    o_src_c   = SRC_IF;
    if (i_req_if && i_req_ls) begin
      o_src_c = (r_last == SRC_IF) ? SRC_LS : SRC_IF;
    end else if (i_req_ls) begin
      o_src_c = SRC_LS;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= SRC_IF;
    end else if (i_take && o_valid_c) begin
      r_last <= o_src_c;
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: shares one byte-wide RAM port between instruction fetch and the
// load/store buffer. Serializes 1/2/4-byte accesses, assembles little-endian
// read data and arbitrates round-robin between the two requesters.
// Ports: clk, rst (sync, active-high); rdy global stall (low = freeze);
// flush aborts reads; io_buffer_full back-pressures I/O-region writes;
// bus carries both request channels and the RAM port.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter logic [1:0]  IO_HI  = IO_HI_DEF
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rdy,
  input  logic      flush,
  input  logic      io_buffer_full,
  mem_ctrl_if.slave bus
);

  state_e            r_state, w_state_n;
  logic [2:0]        r_cnt, w_cnt_n;
  xfer_t             r_xfer, w_xfer_n;
  logic [31:0]       r_data, w_data_n;
  logic [ADDR_W-1:0] r_a, w_a_n, w_a_inc;
  logic [7:0]        r_dout, w_dout_n;
  logic              r_wr, w_wr_n;
  logic              r_if_done, w_if_done_n;
  logic              r_ls_done, w_ls_done_n;
  logic [31:0]       r_if_inst, w_if_inst_n;
  logic [31:0]       r_ls_rdata, w_ls_rdata_n;
  logic              r_stall_q;
  logic [7:0]        r_din_sh;
  logic [7:0]        w_din;
  logic [1:0]        w_ridx, w_widx;
  logic              w_take, w_gnt_valid;
  src_e              w_gnt_src;

  // A requester is deaf in the cycle of its own done pulse
  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_req_if  (bus.if_req & ~r_if_done),
    .i_req_ls  (bus.ls_req & ~r_ls_done),
    .i_take    (w_take),
    .o_valid_c (w_gnt_valid),
    .o_src_c   (w_gnt_src)
  );

  // After a stall the RAM returns the byte at the held mem_a; the byte that was
  // in flight when the stall began is kept in r_din_sh and used on resume.
  assign w_din   = r_stall_q ? r_din_sh : bus.mem_din;
  assign w_ridx  = 2'(r_cnt - 3'd1);
  assign w_widx  = 2'(r_cnt + 3'd1);
  assign w_a_inc = r_a + ADDR_W'(1);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  // Next-state and datapath decode; everything holds while rdy is low
  always_comb begin
    w_state_n    = r_state;
    w_cnt_n      = r_cnt;
    w_xfer_n     = r_xfer;
    w_data_n     = r_data;
    w_a_n        = r_a;
    w_dout_n     = r_dout;
    w_wr_n       = r_wr;
    w_if_done_n  = 1'b0;
    w_ls_done_n  = 1'b0;
    w_if_inst_n  = r_if_inst;
    w_ls_rdata_n = r_ls_rdata;
    w_take       = 1'b0;

    if (rdy) begin
      case (r_state)
        ST_IDLE: begin
          if (!flush && w_gnt_valid) begin
            w_take   = 1'b1;
            w_cnt_n  = 3'd0;
            w_data_n = 32'h0;
            if (w_gnt_src == SRC_LS) begin
              w_xfer_n.nbytes = byte_count(bus.ls_size);
              w_xfer_n.wdata  = bus.ls_wdata;
              w_a_n           = bus.ls_addr;
              if (bus.ls_we) begin
                w_state_n = ST_LS_WR;
                w_dout_n  = bus.ls_wdata[7:0];
                w_wr_n    = !((bus.ls_addr[17:16] == IO_HI) && io_buffer_full);
              end else begin
                w_state_n = ST_LS_RD;
              end
            end else begin
              w_state_n       = ST_IF_RD;
              w_xfer_n.nbytes = 3'd4;
              w_xfer_n.wdata  = 32'h0;
              w_a_n           = bus.if_addr;
            end
          end
        end

        // cnt = k: mem_a shows byte k, mem_din returns byte k-1
        ST_IF_RD, ST_LS_RD: begin
          if (flush) begin
            w_state_n = ST_IDLE;
          end else begin
            w_cnt_n = r_cnt + 3'd1;
            if (r_cnt != 3'd0) begin
              w_data_n[{w_ridx, 3'b000} +: 8] = w_din;
            end
            if (r_cnt < (r_xfer.nbytes - 3'd1)) begin
              w_a_n = w_a_inc;
            end
            if (r_cnt == r_xfer.nbytes) begin
              w_state_n = ST_IDLE;
              if (r_state == ST_IF_RD) begin
                w_if_done_n = 1'b1;
                w_if_inst_n = w_data_n;
              end else begin
                w_ls_done_n  = 1'b1;
                w_ls_rdata_n = w_data_n;
              end
            end
          end
        end

        // cnt = k: byte k is on the port; r_wr low means it is held back
        ST_LS_WR: begin
          if (r_wr) begin
            if (r_cnt == (r_xfer.nbytes - 3'd1)) begin
              w_state_n   = ST_IDLE;
              w_wr_n      = 1'b0;
              w_ls_done_n = 1'b1;
            end else begin
              w_cnt_n  = r_cnt + 3'd1;
              w_a_n    = w_a_inc;
              w_dout_n = r_xfer.wdata[{w_widx, 3'b000} +: 8];
              w_wr_n   = !((w_a_inc[17:16] == IO_HI) && io_buffer_full);
            end
          end else begin
            w_wr_n = !((r_a[17:16] == IO_HI) && io_buffer_full);
          end
        end

        default: w_state_n = ST_IDLE;
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= 3'd0;
      r_xfer     <= '0;
      r_data     <= 32'h0;
      r_a        <= '0;
      r_dout     <= 8'h0;
      r_wr       <= 1'b0;
      r_if_done  <= 1'b0;
      r_ls_done  <= 1'b0;
      r_if_inst  <= 32'h0;
      r_ls_rdata <= 32'h0;
      r_stall_q  <= 1'b0;
      r_din_sh   <= 8'h0;
    end else begin
      r_cnt      <= w_cnt_n;
      r_xfer     <= w_xfer_n;
      r_data     <= w_data_n;
      r_a        <= w_a_n;
      r_dout     <= w_dout_n;
      r_wr       <= w_wr_n;
      r_if_done  <= w_if_done_n;
      r_ls_done  <= w_ls_done_n;
      r_if_inst  <= w_if_inst_n;
      r_ls_rdata <= w_ls_rdata_n;
      r_stall_q  <= ~rdy;
      if (!rdy && !r_stall_q) begin
        r_din_sh <= bus.mem_din;
      end
    end
  end

  assign bus.mem_a    = r_a;
  assign bus.mem_dout = r_dout;
  // A held write strobe must not repeat into the RAM during a stall
  assign bus.mem_wr   = r_wr & rdy;
  assign bus.if_done  = r_if_done;
  assign bus.if_inst  = r_if_inst;
  assign bus.ls_done  = r_ls_done;
  assign bus.ls_rdata = r_ls_rdata;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed testbench for mem_ctrl with a synchronous byte RAM model.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  logic flush;
  logic io_buffer_full;
  int   checks = 0;
  int   errors = 0;

  mem_ctrl_if #(.ADDR_W(32)) bus ();

  mem_ctrl #(.ADDR_W(32), .IO_HI(2'b11)) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .flush          (flush),
    .io_buffer_full (io_buffer_full),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [logic [31:0]];

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return 8'h00;
  endfunction

  // Synchronous read: data for the address of one cycle earlier
  always @(posedge clk) bus.mem_din <= ram_rd(bus.mem_a);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.if_req   = 1'b0;
    bus.if_addr  = 32'h0;
    bus.ls_req   = 1'b0;
    bus.ls_we    = 1'b0;
    bus.ls_size  = SIZE_B;
    bus.ls_addr  = 32'h0;
    bus.ls_wdata = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
    idle_bus();
    repeat (3) step();
    checks++; if (bus.mem_a !== 32'h0) begin errors++; $display("FAIL reset_mem_a got %h want 0", bus.mem_a); end
    checks++; if (bus.mem_dout !== 8'h0) begin errors++; $display("FAIL reset_mem_dout got %h want 0", bus.mem_dout); end
    checks++; if (bus.mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr got %b want 0", bus.mem_wr); end
    checks++; if (bus.if_done !== 1'b0) begin errors++; $display("FAIL reset_if_done got %b want 0", bus.if_done); end
    checks++; if (bus.ls_done !== 1'b0) begin errors++; $display("FAIL reset_ls_done got %b want 0", bus.ls_done); end
    checks++; if (bus.if_inst !== 32'h0) begin errors++; $display("FAIL reset_if_inst got %h want 0", bus.if_inst); end
    checks++; if (bus.ls_rdata !== 32'h0) begin errors++; $display("FAIL reset_ls_rdata got %h want 0", bus.ls_rdata); end
    rst = 1'b0;
    step();
  endtask

  // Both request from reset: LS, IF, LS, IF, LS
  task automatic test_contention();
    int ls_k[4] = '{-1, -1, -1, -1};
    int if_k[4] = '{-1, -1, -1, -1};
    int nls = 0;
    int nif = 0;
    logic [31:0] ls_d0 = 32'hx;
    logic [31:0] if_d0 = 32'hx;
    logic [31:0] a4 = 32'hx;
    bus.if_req = 1'b1; bus.if_addr = 32'h1000;
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_size = SIZE_B; bus.ls_addr = 32'h20;
    for (int k = 1; k <= 23; k++) begin
      step();
      if (k == 4) a4 = bus.mem_a;
      if (bus.ls_done === 1'b1) begin
        if (nls == 0) ls_d0 = bus.ls_rdata;
        if (nls < 4) ls_k[nls] = k;
        nls++;
      end
      if (bus.if_done === 1'b1) begin
        if (nif == 0) if_d0 = bus.if_inst;
        if (nif < 4) if_k[nif] = k;
        nif++;
      end
      if (k == 19) idle_bus();
    end
    checks++; if (ls_k[0] != 3) begin errors++; $display("FAIL cont_ls_first_cycle got %0d want 3", ls_k[0]); end
    checks++; if (ls_d0 !== 32'h0000005A) begin errors++; $display("FAIL cont_ls_rdata got %h want 0000005a", ls_d0); end
    checks++; if (a4 !== 32'h1000) begin errors++; $display("FAIL cont_if_grant_addr got %h want 00001000", a4); end
    checks++; if (if_k[0] != 9) begin errors++; $display("FAIL cont_if_first_cycle got %0d want 9", if_k[0]); end
    checks++; if (if_d0 !== 32'h00000513) begin errors++; $display("FAIL cont_if_inst got %h want 00000513", if_d0); end
    checks++; if (ls_k[1] != 12) begin errors++; $display("FAIL cont_ls_second_cycle got %0d want 12", ls_k[1]); end
    checks++; if (if_k[1] != 18) begin errors++; $display("FAIL cont_if_second_cycle got %0d want 18", if_k[1]); end
    checks++; if (ls_k[2] != 21) begin errors++; $display("FAIL cont_ls_third_cycle got %0d want 21", ls_k[2]); end
    checks++; if (nls != 3 || nif != 2) begin errors++; $display("FAIL cont_pulse_count got ls=%0d if=%0d want ls=3 if=2", nls, nif); end
  endtask

  task automatic test_word_fetch();
    int done_k = -1;
    int nwr = 0;
    logic [31:0] inst = 32'hx;
    bus.if_req = 1'b1; bus.if_addr = 32'h1000;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k <= 4) begin
        checks++;
        if (bus.mem_a !== 32'h1000 + 32'(k - 1)) begin
          errors++; $display("FAIL fetch_addr_walk k=%0d got %h want %h", k, bus.mem_a, 32'h1000 + 32'(k - 1));
        end
      end
      if (bus.mem_wr === 1'b1) nwr++;
      if (bus.if_done === 1'b1 && done_k < 0) begin done_k = k; inst = bus.if_inst; bus.if_req = 1'b0; end
    end
    checks++; if (done_k != 6) begin errors++; $display("FAIL fetch_latency got %0d want 6", done_k); end
    checks++; if (inst !== 32'h00000513) begin errors++; $display("FAIL fetch_inst got %h want 00000513", inst); end
    checks++; if (nwr != 0) begin errors++; $display("FAIL fetch_no_write got %0d writes want 0", nwr); end
  endtask

  task automatic test_half_load();
    int done_k = -1;
    logic [31:0] d = 32'hx;
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_size = SIZE_H; bus.ls_addr = 32'h40;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 1) bus.ls_req = 1'b0;
      if (bus.ls_done === 1'b1 && done_k < 0) begin done_k = k; d = bus.ls_rdata; end
    end
    checks++; if (done_k != 4) begin errors++; $display("FAIL hload_latency got %0d want 4", done_k); end
    checks++; if (d !== 32'h0000BEEF) begin errors++; $display("FAIL hload_rdata got %h want 0000beef", d); end
  endtask

  task automatic test_half_store();
    int done_k = -1;
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_size = SIZE_H;
    bus.ls_addr = 32'h0FFF_FFFF; bus.ls_wdata = 32'h0000_1234;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 1) begin
        bus.ls_req = 1'b0;
        checks++;
        if ({bus.mem_wr, bus.mem_a, bus.mem_dout} !== {1'b1, 32'h0FFF_FFFF, 8'h34}) begin
          errors++; $display("FAIL hstore_byte0 got wr=%b a=%h d=%h want wr=1 a=0fffffff d=34", bus.mem_wr, bus.mem_a, bus.mem_dout);
        end
      end
      if (k == 2) begin
        checks++;
        if ({bus.mem_wr, bus.mem_a, bus.mem_dout} !== {1'b1, 32'h1000_0000, 8'h12}) begin
          errors++; $display("FAIL hstore_byte1_wrap got wr=%b a=%h d=%h want wr=1 a=10000000 d=12", bus.mem_wr, bus.mem_a, bus.mem_dout);
        end
      end
      if (k == 3) begin
        checks++;
        if (bus.mem_wr !== 1'b0) begin errors++; $display("FAIL hstore_wr_after got %b want 0", bus.mem_wr); end
      end
      if (bus.ls_done === 1'b1 && done_k < 0) done_k = k;
    end
    checks++; if (done_k != 3) begin errors++; $display("FAIL hstore_done_cycle got %0d want 3", done_k); end
  endtask

  task automatic test_flush_fetch();
    int nif = 0;
    int done_k = -1;
    logic [31:0] a5 = 32'hx;
    logic [31:0] d = 32'hx;
    bus.if_req = 1'b1; bus.if_addr = 32'h1000;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (bus.if_done === 1'b1) nif++;
      if (bus.ls_done === 1'b1 && done_k < 0) begin done_k = k; d = bus.ls_rdata; end
      if (k == 5) begin a5 = bus.mem_a; bus.ls_req = 1'b0; end
      if (k == 3) begin flush = 1'b1; bus.if_req = 1'b0; end
      if (k == 4) begin
        flush = 1'b0;
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_size = SIZE_B; bus.ls_addr = 32'h20;
      end
    end
    checks++; if (nif != 0) begin errors++; $display("FAIL flush_no_if_done got %0d pulses want 0", nif); end
    checks++; if (a5 !== 32'h20) begin errors++; $display("FAIL flush_idle_next got mem_a=%h want 00000020", a5); end
    checks++; if (done_k != 7) begin errors++; $display("FAIL flush_next_ls_cycle got %0d want 7", done_k); end
    checks++; if (d !== 32'h0000005A) begin errors++; $display("FAIL flush_next_ls_rdata got %h want 0000005a", d); end
  endtask

  task automatic test_flush_store();
    int done_k = -1;
    int nwr = 0;
    logic [31:0] wd = 32'hA1B2_C3D4;
    logic [7:0]  eb;
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_size = SIZE_W;
    bus.ls_addr = 32'h100; bus.ls_wdata = wd;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (bus.mem_wr === 1'b1) nwr++;
      if (k <= 4) begin
        eb = 8'(wd >> (8 * (k - 1)));
        checks++;
        if ({bus.mem_wr, bus.mem_a, bus.mem_dout} !== {1'b1, 32'h100 + 32'(k - 1), eb}) begin
          errors++; $display("FAIL fstore_byte k=%0d got wr=%b a=%h d=%h want wr=1 a=%h d=%h", k, bus.mem_wr, bus.mem_a, bus.mem_dout, 32'h100 + 32'(k - 1), eb);
        end
      end
      if (bus.ls_done === 1'b1 && done_k < 0) done_k = k;
      if (k == 1) begin bus.ls_req = 1'b0; flush = 1'b1; end
      if (k == 2) flush = 1'b0;
    end
    checks++; if (nwr != 4) begin errors++; $display("FAIL fstore_write_count got %0d want 4", nwr); end
    checks++; if (done_k != 5) begin errors++; $display("FAIL fstore_done_cycle got %0d want 5", done_k); end
  endtask

  task automatic test_rdy_drop();
    int done_k = -1;
    int nwr = 0;
    int ndone = 0;
    logic [31:0] d = 32'hx;
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_size = SIZE_W; bus.ls_addr = 32'h40;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (bus.mem_wr === 1'b1) nwr++;
      if (bus.ls_done === 1'b1) begin
        ndone++;
        if (done_k < 0) begin done_k = k; d = bus.ls_rdata; end
      end
      if (k == 1) begin bus.ls_req = 1'b0; rdy = 1'b0; end
      if (k == 4) rdy = 1'b1;
    end
    checks++; if (done_k != 9) begin errors++; $display("FAIL rdy_done_cycle got %0d want 9", done_k); end
    checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rdy_rdata got %h want deadbeef", d); end
    checks++; if (nwr != 0 || ndone != 1) begin errors++; $display("FAIL rdy_side_effects got writes=%0d dones=%0d want 0 and 1", nwr, ndone); end
  endtask

  task automatic test_io_backpressure();
    int done_k = -1;
    int nwr = 0;
    int nlow = 0;
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_size = SIZE_B;
    bus.ls_addr = 32'h0003_0000; bus.ls_wdata = 32'h0000_00AB;
    io_buffer_full = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (bus.mem_wr === 1'b1) nwr++;
      if (k <= 4 && bus.mem_wr === 1'b0) nlow++;
      if (k == 5) begin
        checks++;
        if ({bus.mem_wr, bus.mem_a, bus.mem_dout} !== {1'b1, 32'h0003_0000, 8'hAB}) begin
          errors++; $display("FAIL io_write got wr=%b a=%h d=%h want wr=1 a=00030000 d=ab", bus.mem_wr, bus.mem_a, bus.mem_dout);
        end
      end
      if (bus.ls_done === 1'b1 && done_k < 0) done_k = k;
      if (k == 1) bus.ls_req = 1'b0;
      if (k == 4) io_buffer_full = 1'b0;
    end
    checks++; if (nlow != 4) begin errors++; $display("FAIL io_held_cycles got %0d want 4", nlow); end
    checks++; if (nwr != 1) begin errors++; $display("FAIL io_write_count got %0d want 1", nwr); end
    checks++; if (done_k != 6) begin errors++; $display("FAIL io_done_cycle got %0d want 6", done_k); end
  endtask

  task automatic gap();
    idle_bus();
    flush = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0;
    repeat (2) step();
  endtask

  initial begin
    ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h05; ram[32'h1002] = 8'h00; ram[32'h1003] = 8'h00;
    ram[32'h20]   = 8'h5A;
    ram[32'h40]   = 8'hEF; ram[32'h41]   = 8'hBE; ram[32'h42]   = 8'hAD; ram[32'h43]   = 8'hDE;

    test_reset();
    test_contention();      gap();
    test_word_fetch();      gap();
    test_half_load();       gap();
    test_half_store();      gap();
    test_flush_fetch();     gap();
    test_flush_store();     gap();
    test_rdy_drop();        gap();
    test_io_backpressure(); gap();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller that shares the single byte-wide RAM port between the instruction fetcher (fed by the PC register) and the load/store buffer. It serializes 1/2/4-byte accesses into byte cycles, assembles little-endian read data, and arbitrates round-robin between the two requesters. It honours global `rdy` stalls, misprediction flush, and UART back-pressure.

## Interface
- `ADDR_W`, default 32: address width.
- `IO_HI`, default 2'b11: value of `addr[17:16]` that marks the I/O region (0x30000 and above).

Ports (clock and reset first):
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `rdy` in 1: global ready; low freezes the block.
- `flush` in 1: misprediction clear.
- `if_req` in 1: instruction fetch request.
- `if_addr` in ADDR_W: fetch address.
- `if_done` out 1: one-cycle pulse; `if_inst` is valid in that cycle.
- `if_inst` out 32: fetched instruction.
- `ls_req` in 1: load/store request.
- `ls_we` in 1: 1 = store.
- `ls_size` in 2: 0 = byte, 1 = half, 2 = word (3 is illegal; treated as word).
- `ls_addr` in ADDR_W: load/store address.
- `ls_wdata` in 32: store data.
- `ls_done` out 1: one-cycle pulse.
- `ls_rdata` out 32: load data, zero-extended; sign extension belongs to the LSB.
- `mem_din` in 8: RAM read byte; belongs to the address presented one cycle earlier.
- `mem_dout` out 8: write byte.
- `mem_a` out ADDR_W: byte address.
- `mem_wr` out 1: 1 = write.
- `io_buffer_full` in 1: UART transmit FIFO full.

## Operation
- FSM states: IDLE, IF_RD, LS_RD, LS_WR.
- Byte counter `cnt` is 3 bits. Byte count `N`:
  - `N = 4` for fetch.
  - `N = 1 << ls_size` for load/store.
- **IDLE:** samples `if_req`/`ls_req` and latches address, size, wdata and requester.
- **Arbitration:**
  - If only one requester is pending, it is granted.
  - If both are pending, the requester not served last is granted.
  - `last` resets to IF, so LS wins the first contention.
- **Byte addressing:** byte k uses address `addr+k`, computed modulo 2^ADDR_W. Wrap-around is allowed and not flagged.
- **Read data:** byte k is stored into bits `[8k+7:8k]`. Unused upper bytes are 0.
- **Write data:** `mem_dout = wdata[8k+7:8k]` with `mem_wr = 1`.
  - Writes to the I/O region (`addr[17:16] == IO_HI`) while `io_buffer_full = 1` hold the current byte with `mem_wr = 0` until the flag clears.
- **Completion:** on the done pulse the FSM is back in IDLE.
  - A requester's `req` is ignored in the cycle its own `done` is high, so it has one cycle to drop or change the request.
  - The other requester may be granted in that cycle.
- **flush:**
  - Aborts IF_RD and LS_RD: IDLE next cycle, no done pulse, partial data discarded.
  - LS_WR is unaffected and completes with `ls_done`, because committed stores must land.
  - No new grant is made in the flush cycle.
- **rdy low:**
  - All registers hold and `mem_wr` is forced to 0.
  - `mem_a` holds, so the pending read byte is re-captured after resume.
  - `done` pulses are not generated while `rdy` is low.
- **Reset values:** state IDLE, `cnt` 0, `last` IF, `mem_a` 0, `mem_dout` 0, `mem_wr` 0, `if_done` 0, `ls_done` 0, `if_inst` 0, `ls_rdata` 0.
- **Reset mid-transaction:** the transaction is dropped silently. A half-written word is accepted as is.

## Timing
- Request sampled at edge T, with no stall.
- **Read:**
  - `mem_a = addr+k` during cycle T+1+k, for k = 0..N-1.
  - Byte k is captured at the end of cycle T+2+k.
  - `done` and data are valid in cycle T+N+2.
  - Fetch latency is 6 cycles; byte-load latency is 3 cycles.
- **Write:**
  - Byte k is on the port with `mem_wr = 1` in cycle T+1+k.
  - `done` is in cycle T+N+1, so a word store takes 5 cycles.
- **Back-to-back:** the next grant is sampled in the done cycle, so there is no idle bubble between transactions.
- **Stalls:** each `rdy = 0` cycle or I/O-full stall cycle adds exactly one cycle.
- **Registered signals:** `mem_a`, `mem_dout`, `mem_wr`, done and data outputs are all registered. No combinational path from `*_req` to the RAM port.

## Structure
- Shared defines header holds:
  - `AddrType`.
  - Size codes `SIZE_B`/`SIZE_H`/`SIZE_W`.
  - FSM state encodings.
  - `IO_HI`.
- One sub-module: `rr_arb2`, a 2-way round-robin arbiter with a `last` register that updates on grant. Byte sequencing stays in `mem_ctrl`.

## Test plan
- **Word fetch:** `if_req` with `if_addr = 0x1000`, RAM bytes 13 05 00 00 → `mem_a` walks 0x1000..0x1003; `if_done` pulses at T+6 with `if_inst = 0x00000513`.
- **Contention:**
  - `if_req` and `ls_req` (load byte at 0x20) asserted together from reset → LS served first; `ls_done` at T+3 with `ls_rdata = 0x000000XX`.
  - IF is then granted in the `ls_done` cycle.
  - Alternation holds under sustained contention.
- **Halfword store:** 0x1234 to 0x0FFF_FFFF → writes 0x34 at 0x0FFFFFFF, then 0x12 at 0x10000000; `ls_done` at T+3.
- **Flush:** flush at T+3 of a fetch → no `if_done`, IDLE next cycle.
  - Flush during a word store still yields four writes and `ls_done`.
- **rdy drop:** `rdy` low for 3 cycles mid-load → `mem_wr` stays 0, done is delayed by exactly 3 cycles, data is correct.
- **I/O back-pressure:** byte store to 0x30000 with `io_buffer_full` high for 4 cycles → `mem_wr` is low for 4 cycles, then a single write; `ls_done` follows.
